// File: rtl/dwt97_pkg.sv
// Shared constants and types for the DWT 9/7 frame path.
//   ExpandSize  : samples mirrored on each side of a line by the border expander
//   MinLineLen  : shortest line the expander can mirror without folding twice
//   seq_state_t : frame sequencer state encoding
package dwt97_pkg;

  localparam int ExpandSize = 4;
  localparam int MinLineLen = ExpandSize + 1;

  typedef enum logic [1:0] {
    SeqIdle  = 2'd0,
    SeqRun   = 2'd1,
    SeqDrain = 2'd2,
    SeqDone  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/dwt_frame_sequencer_wrap_counter.sv
// Up-counter that wraps to zero after reaching a programmable terminal value.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous clear (start of a new frame)
//   en_i    : count enable
//   last_i  : terminal value; the enabled increment from here goes to zero
//   count_o : current count
//   wrap_o  : combinational pulse, high when an enabled increment wraps
module dwt_frame_sequencer_wrap_counter #(
  parameter int Width = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_reg;

  assign wrap_o  = en_i && (count_reg == last_i);
  assign count_o = count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_reg <= '0;
    end else if (en_i) begin
      count_reg <= wrap_o ? '0 : count_reg + Width'(1);
    end
  end

endmodule

// File: rtl/dwt_frame_sequencer.sv
// Frame controller in front of the DWT 9/7 border expander.
// Latches a frame geometry on start_i, forwards raw sample pairs with sof/eol
// framing, counts completed lines at the expander output and reports done.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   start_i, cfg_width_i/height_i : frame request and geometry (Idle only)
//   busy_o, done_o, err_o         : status (busy level, done/err pulses)
//   s_valid_i/s_ready_o/s_data_i  : raw pair stream from the source
//   m_valid_o/m_ready_i/m_sof_o/m_eol_o/m_data_o : stream to the expander
//   mon_valid_i/mon_ready_i/mon_eol_i            : expander output tap
module dwt_frame_sequencer
  import dwt97_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int WidthW    = 12,
  parameter int HeightW   = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [WidthW-1:0]      cfg_width_i,
  input  logic [HeightW-1:0]     cfg_height_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [2*DataWidth-1:0] s_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  input  logic                   mon_valid_i,
  input  logic                   mon_ready_i,
  input  logic                   mon_eol_i
);

  localparam logic [WidthW-1:0] MinLen = WidthW'(MinLineLen);

  seq_state_t         state_reg;
  logic [WidthW-1:0]  width_reg;
  logic [HeightW-1:0] height_reg;
  logic [HeightW-1:0] out_rows_reg;
  logic [HeightW-1:0] out_rows_next;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;

  logic               run;
  logic               counting;
  logic               cfg_ok;
  logic               accept;
  logic               in_hs;
  logic               mon_hs;
  logic               rows_met;
  logic [WidthW-1:0]  col;
  logic [HeightW-1:0] row;
  logic               col_wrap;
  logic               frame_last;

  assign run      = (state_reg == SeqRun);
  assign counting = run || (state_reg == SeqDrain);
  assign cfg_ok   = (cfg_width_i >= MinLen) && (cfg_height_i != '0);
  assign accept   = (state_reg == SeqIdle) && start_i && cfg_ok;
  assign in_hs    = run && s_valid_i && m_ready_i;
  assign mon_hs   = counting && mon_valid_i && mon_ready_i && mon_eol_i;

  // Termination looks at the count including this cycle's monitored eol, so a
  // final eol landing with the last input beat skips Drain entirely.
  assign out_rows_next = out_rows_reg + HeightW'(mon_hs);
  assign rows_met      = (out_rows_next == height_reg);

  dwt_frame_sequencer_wrap_counter #(.Width(WidthW)) u_col (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .en_i    (in_hs),
    .last_i  (width_reg - WidthW'(1)),
    .count_o (col),
    .wrap_o  (col_wrap)
  );

  // The row counter wrapping is exactly the last input beat of the frame.
  dwt_frame_sequencer_wrap_counter #(.Width(HeightW)) u_row (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .en_i    (in_hs && col_wrap),
    .last_i  (height_reg - HeightW'(1)),
    .count_o (row),
    .wrap_o  (frame_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= SeqIdle;
      width_reg    <= '0;
      height_reg   <= '0;
      out_rows_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (counting) begin
        out_rows_reg <= out_rows_next;
      end
      case (state_reg)
        SeqIdle: begin
          if (start_i) begin
            if (cfg_ok) begin
              width_reg    <= cfg_width_i;
              height_reg   <= cfg_height_i;
              out_rows_reg <= '0;
              busy_reg     <= 1'b1;
              state_reg    <= SeqRun;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        SeqRun: begin
          if (frame_last) begin
            if (rows_met) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= SeqDone;
            end else begin
              state_reg <= SeqDrain;
            end
          end
        end
        SeqDrain: begin
          if (rows_met) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= SeqDone;
          end
        end
        SeqDone: begin
          state_reg <= SeqIdle;
        end
        default: begin
          state_reg <= SeqIdle;
        end
      endcase
    end
  end

  // Pure pass-through while running; s_ready_o depends only on m_ready_i.
  assign m_valid_o = run && s_valid_i;
  assign s_ready_o = run && m_ready_i;
  assign m_data_o  = s_data_i;
  assign m_sof_o   = run && (row == '0) && (col == '0);
  assign m_eol_o   = run && (col == width_reg - WidthW'(1));

  assign busy_o = busy_reg;
  assign done_o = done_reg;
  assign err_o  = err_reg;

endmodule

// File: tb/tb_dwt_frame_sequencer.sv
// Self-checking bench for dwt_frame_sequencer: configuration table, directed
// frames, reset abort, coincident termination and randomized stalled frames
// checked against a beat-level frame model with an expander output model.
module tb_dwt_frame_sequencer;
  import dwt97_pkg::*;

  localparam int DW = 16;
  localparam int WW = 12;
  localparam int HW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] cfg_w = '0;
  logic [HW-1:0] cfg_h = '0;
  logic          busy, done, err;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [2*DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_sof, m_eol;
  logic [2*DW-1:0] m_data;
  logic          mon_valid = 1'b0;
  logic          mon_ready = 1'b0;
  logic          mon_eol = 1'b0;

  int vec_count  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  dwt_frame_sequencer #(.DataWidth(DW), .WidthW(WW), .HeightW(HW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cfg_width_i  (cfg_w),
    .cfg_height_i (cfg_h),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_data_i     (s_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_sof_o      (m_sof),
    .m_eol_o      (m_eol),
    .m_data_o     (m_data),
    .mon_valid_i  (mon_valid),
    .mon_ready_i  (mon_ready),
    .mon_eol_i    (mon_eol)
  );

  typedef struct {
    int w;
    int h;
    bit exp_err;
  } cfg_vec_t;

  cfg_vec_t cfg_tab[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset with the stream inputs active so a missing state gate shows up.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    mon_valid = 1'b0; mon_ready = 1'b0; mon_eol = 1'b0;
    @(negedge clk);
    #1;
    check({tag, ".busy"},    busy,    0);
    check({tag, ".done"},    done,    0);
    check({tag, ".err"},     err,     0);
    check({tag, ".m_valid"}, m_valid, 0);
    check({tag, ".s_ready"}, s_ready, 0);
    check({tag, ".sof"},     m_sof,   0);
    check({tag, ".eol"},     m_eol,   0);
    $display("reset %s: outputs idle", tag);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  // One frame against the model. stall: percent of cycles each handshake
  // party withholds; mid_at: beat index at which a second start is pulsed
  // (-1 none); abort_at: beat count after which reset is asserted (0 none).
  task automatic run_frame(input int w, input int h, input int stall,
                           input int mid_at, input int abort_at);
    int total, sent, lines_pend, mon_beat, out_rows, cyc, line_len;
    bit done_due, finished, prev_stall, in_hs, mon_hs, in_run, hold;
    logic [2*DW-1:0] prev_data;
    logic prev_sof, prev_eol;
    logic [15:0] base;
    total = w * h; sent = 0; lines_pend = 0; mon_beat = 0; out_rows = 0;
    cyc = 0; line_len = w + 2 * ExpandSize;
    done_due = 0; finished = 0; prev_stall = 0; hold = 0;
    prev_data = '0; prev_sof = 0; prev_eol = 0;
    base = 16'($urandom);
    $display("frame w=%0d h=%0d stall=%0d mid=%0d abort=%0d", w, h, stall, mid_at, abort_at);
    @(negedge clk);
    start = 1'b1; cfg_w = WW'(w); cfg_h = HW'(h);
    s_valid = 0; m_ready = 0; mon_valid = 0; mon_ready = 0; mon_eol = 0;
    @(negedge clk);
    start = 1'b0;
    while (!finished) begin
      in_run = (sent < total);
      if (!hold) begin
        s_valid = in_run && (stall == 0 || $urandom_range(99) >= stall);
        s_data  = {base, 16'(sent)};
      end
      m_ready   = (stall == 0) || ($urandom_range(99) >= stall);
      mon_valid = (lines_pend > 0) && (stall == 0 || $urandom_range(99) >= stall);
      mon_ready = (stall == 0) || ($urandom_range(99) >= stall);
      mon_eol   = mon_valid && (mon_beat == line_len - 1);
      start     = (mid_at >= 0) && (sent == mid_at) && in_run;
      if (start) begin
        cfg_w = WW'(w + 3);
        cfg_h = HW'(h + 1);
      end
      #1;
      check("busy",    busy,    !done_due);
      check("done",    done,    done_due);
      check("err",     err,     0);
      check("m_valid", m_valid, s_valid && in_run);
      check("s_ready", s_ready, m_ready && in_run);
      if (m_valid) begin
        check("m_data", m_data, {base, 16'(sent)});
        check("sof",    m_sof,  sent == 0);
        check("eol",    m_eol,  (sent % w) == w - 1);
      end
      if (prev_stall) begin
        check("stall.valid", m_valid, 1);
        check("stall.data",  m_data,  prev_data);
        check("stall.sof",   m_sof,   prev_sof);
        check("stall.eol",   m_eol,   prev_eol);
      end
      if (done_due) begin
        finished = 1;
        $display("frame done after %0d cycles", cyc);
      end else begin
        in_hs  = s_valid && m_ready && in_run;
        mon_hs = mon_valid && mon_ready;
        prev_stall = m_valid && !m_ready;
        prev_data = m_data; prev_sof = m_sof; prev_eol = m_eol;
        if (in_hs)
          $display("beat %0d data=%h sof=%b eol=%b", sent, m_data, m_sof, m_eol);
        @(posedge clk);
        if (in_hs) begin
          sent++;
          if ((sent % w) == 0) lines_pend++;
        end
        if (mon_hs) begin
          if (mon_eol) begin
            mon_beat = 0;
            lines_pend--;
            out_rows++;
            if (out_rows == h && sent == total) done_due = 1;
          end else begin
            mon_beat++;
          end
        end
        hold = s_valid && !in_hs;
        cyc++;
        if (cyc > 5000) begin
          vec_count++;
          fail_count++;
          $display("FAIL frame_timeout: got %0d cycles required under 5000", cyc);
          finished = 1;
          do_reset("timeout");
        end else if (abort_at > 0 && sent == abort_at) begin
          do_reset("abort");
          finished = 1;
          abort_at = -1;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (abort_at >= 0 && cyc <= 5000) begin
      s_valid = 0; m_ready = 0; mon_valid = 0; mon_ready = 0; mon_eol = 0;
      @(negedge clk);
      #1;
      check("post.done", done, 0);
      check("post.busy", busy, 0);
    end
  endtask

  initial begin
    cfg_tab[0] = '{w: 4,    h: 2,    exp_err: 1'b1};
    cfg_tab[1] = '{w: 5,    h: 0,    exp_err: 1'b1};
    cfg_tab[2] = '{w: 1,    h: 1,    exp_err: 1'b1};
    cfg_tab[3] = '{w: 0,    h: 7,    exp_err: 1'b1};
    cfg_tab[4] = '{w: 5,    h: 1,    exp_err: 1'b0};
    cfg_tab[5] = '{w: 4095, h: 4095, exp_err: 1'b0};

    repeat (2) @(negedge clk);
    do_reset("power_on");

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b1; cfg_w = WW'(cfg_tab[i].w); cfg_h = HW'(cfg_tab[i].h);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("cfg.err",  err,  cfg_tab[i].exp_err);
      check("cfg.busy", busy, !cfg_tab[i].exp_err);
      @(negedge clk);
      #1;
      check("cfg.err_pulse", err,  0);
      check("cfg.busy_hold", busy, !cfg_tab[i].exp_err);
      $display("cfg w=%0d h=%0d err=%b busy=%b", cfg_tab[i].w, cfg_tab[i].h, err, busy);
      do_reset("cfg");
    end

    run_frame(8, 3, 0, -1, 0);
    run_frame(5, 2, 40, -1, 0);
    run_frame(5, 3, 30, 6, 0);
    run_frame(5, 4, 0, -1, 7);
    run_frame(6, 1, 0, -1, 0);

    // Last monitored eol on the same cycle as the last input beat.
    @(negedge clk);
    start = 1'b1; cfg_w = WW'(5); cfg_h = HW'(1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; m_ready = 1; s_data = 32'(i);
      mon_valid = (i == 4); mon_ready = (i == 4); mon_eol = (i == 4);
      #1;
      check("coin.sof", m_sof, i == 0);
      check("coin.eol", m_eol, i == 4);
      $display("coin beat %0d sof=%b eol=%b", i, m_sof, m_eol);
      @(negedge clk);
    end
    s_valid = 0; m_ready = 0; mon_valid = 0; mon_ready = 0; mon_eol = 0;
    #1;
    check("coin.done", done, 1);
    check("coin.busy", busy, 0);
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        #1;
        if (done) extra++;
      end
      check("coin.done_once", extra, 0);
    end

    repeat (6) begin
      run_frame($urandom_range(12, 5), $urandom_range(4, 1), $urandom_range(50, 0), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dwt_frame_sequencer.md
# dwt_frame_sequencer

Frame-level controller in front of the DWT 9/7 border expander. It latches a frame geometry on `start_i` and forwards raw sample pairs from the line source to the expander, generating `sof` on the first pair of the frame and `eol` on the last pair of each line. It also monitors the expander's output handshake and counts completed extended lines, then reports frame completion. It sequences exactly one frame per `start_i` and sits between the line-buffer/read DMA and the border expander.

## Interface
Parameters:
- `DataWidth`, 16, width of one sample; a data beat carries a pair (`2*DataWidth`).
- `WidthW`, 12, bit width of the line-length field (pairs per line).
- `HeightW`, 12, bit width of the line-count field.

Ports:
- `clk_i` in 1: single clock, all logic on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: frame start request, sampled only in Idle.
- `cfg_width_i` in `WidthW`: pairs per line, sampled with `start_i`.
- `cfg_height_i` in `HeightW`: lines per frame, sampled with `start_i`.
- `busy_o` out 1: high in Run and Drain.
- `done_o` out 1: one-cycle pulse when the frame is complete.
- `err_o` out 1: one-cycle pulse when `start_i` is rejected.
- `s_valid_i` in 1 / `s_ready_o` out 1 / `s_data_i` in `2*DataWidth`: raw pair stream from the source.
- `m_valid_o` out 1 / `m_ready_i` in 1 / `m_sof_o` out 1 / `m_eol_o` out 1 / `m_data_o` out `2*DataWidth`: stream to the expander.
- `mon_valid_i`, `mon_ready_i`, `mon_eol_i` in 1 each: tap of the expander output handshake.

## Operation
- States: Idle, Run, Drain, Done.
- **Idle**
  - `start_i` with `cfg_width_i >= MinLineLen` and `cfg_height_i != 0`: latch the config, clear the counters, go to Run.
  - `start_i` with any other config: pulse `err_o`, stay in Idle.
- **Run**
  - Pass-through, no storage: `m_valid_o = s_valid_i`, `s_ready_o = m_ready_i`, `m_data_o = s_data_i`.
  - `col` counts input handshakes and wraps from width-1 to 0. `row` increments on that wrap.
  - `m_sof_o = (row==0 && col==0)`. `m_eol_o = (col==width-1)`.
  - The handshake at `row==height-1 && col==width-1` goes to Drain.
- **Drain**
  - `s_ready_o = 0`, `m_valid_o = 0`.
  - Wait until `out_rows == height`.
- **Done**
  - `done_o = 1` for one cycle, then Idle.
- **Output counter**
  - `out_rows` increments on `mon_valid_i & mon_ready_i & mon_eol_i` in Run and Drain. It is ignored in Idle.
  - The test `out_rows == height` uses the post-increment value. If it is met on the same cycle as the last input handshake, go directly to Done.
- `start_i` is ignored outside Idle and causes no `err_o`.
- `m_sof_o` and `m_eol_o` are both valid with `m_valid_o`. When width equals 1 they could coincide, but that width is rejected.

## Timing
- Reset values: state Idle; `busy_o`, `done_o`, `err_o`, `m_valid_o`, `s_ready_o`, `m_sof_o`, `m_eol_o` all 0; counters 0.
- Forward path in Run is combinational, with zero latency. Registers exist only in the expander.
- `busy_o` rises the cycle after an accepted `start_i`.
- `done_o` comes one cycle after the `out_rows` terminal count.
- `err_o` comes one cycle after a rejected `start_i`.
- No back-to-back frames: the earliest next start is the cycle after `done_o` (Idle).
- Handshake rules:
  - Data, sof and eol are stable while `m_valid_o & !m_ready_i`.
  - No `s_valid_i` to `s_ready_o` combinational dependency is allowed.
- Counter widths: `col` is `WidthW` bits, `row` and `out_rows` are `HeightW` bits. Comparisons are against the latched config, not live inputs.
- `rst_i` mid-frame aborts immediately to Idle with no `done_o`. The expander must be reset on the same `rst_i`.

## Structure
- Package `dwt97_pkg` holds:
  - `ExpandSize = 4`.
  - `MinLineLen = ExpandSize + 1`.
  - The state enum `seq_state_t` (Idle, Run, Drain, Done), shared with the expander's constants.
- One natural sub-module: `WrapCounter` (parameterised width, enable, terminal value, wrap pulse), used for `col` and `row`.

## Test plan
- Width 8, height 3, source always valid, sink always ready:
  - 24 input pairs in total.
  - `m_sof_o` only on beat 0.
  - `m_eol_o` on beats 7, 15 and 23.
  - Drive `mon_*` from an expander model (16 beats per line).
  - `done_o` one cycle after the 3rd monitored eol.
- Width 4, height 2 start → `err_o` pulse next cycle, `busy_o` stays 0. The same with width 5 and height 0 → `err_o`.
- Width 5, height 2 with random `s_valid_i` and `m_ready_i` stalls → data, sof and eol held stable across stalls, and order preserved (incrementing pattern 0..9).
- `start_i` pulsed again mid-frame with a different config → ignored; framing still uses width 5, no `err_o`.
- `rst_i` asserted after 7 beats of a width-5, height-4 frame → the next cycle is Idle with all outputs 0. A new start with width 6, height 1 then gives `sof` on beat 0 and `eol` on beat 5.
- The last monitored eol coincides with the last input handshake → direct Run to Done, `done_o` exactly once.
